// File: rtl/busca_instrucoes_if.sv
// Fetch-unit bus: instruction memory read port plus the valid/ready queue
// toward decode and the branch redirect inputs.
interface busca_instrucoes_if;
   logic [7:0] address;
   logic [7:0] instruction_in;
   logic [7:0] instr;
   logic [7:0] instr_pc;
   logic       instr_valid;
   logic       instr_ready;
   logic       desvio;
   logic [7:0] desvio_alvo;

   modport master (
      output address,
      input  instruction_in,
      output instr,
      output instr_pc,
      output instr_valid,
      input  instr_ready,
      input  desvio,
      input  desvio_alvo
   );

   modport slave (
      input  address,
      output instruction_in,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      output instr_ready,
      output desvio,
      output desvio_alvo
   );
endinterface

// File: rtl/busca_instrucoes.sv
// Instruction fetch unit: owns the PC, reads a falling-edge-registered
// instruction memory and buffers {instruction, pc} in a 2-entry queue.
module busca_instrucoes (
   input  logic                clk,
   input  logic                rst_n,
   busca_instrucoes_if.master  bus
);

   logic [7:0] pc_q, pc_d;
   logic       primed_q;
   logic [1:0] count_q, count_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [7:0] fifo_instr_q [2];
   logic [7:0] fifo_pc_q    [2];

   logic valid;
   logic pop;
   logic cap;

   assign valid = (count_q != 2'd0);
   assign pop   = valid & bus.instr_ready;
   // A full queue may still capture when the head leaves on the same edge.
   assign cap   = primed_q & ~bus.desvio & ((count_q != 2'd2) | pop);

   always_comb begin
      pc_d     = pc_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (bus.desvio) begin
         pc_d     = bus.desvio_alvo;
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (cap) begin
            pc_d     = pc_q + 8'd1;
            wr_ptr_d = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, cap} - {1'b0, pop};
      end
   end

   // primed waits one full cycle so the memory has seen a stable address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= 8'h00;
         primed_q <= 1'b0;
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         primed_q <= 1'b1;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (cap) begin
         fifo_instr_q[wr_ptr_q] <= bus.instruction_in;
         fifo_pc_q[wr_ptr_q]    <= pc_q;
      end
   end

   assign bus.address     = pc_q;
   assign bus.instr_valid = valid;
   assign bus.instr       = valid ? fifo_instr_q[rd_ptr_q] : 8'h00;
   assign bus.instr_pc    = valid ? fifo_pc_q[rd_ptr_q]    : 8'h00;

endmodule

// File: tb/tb_busca_instrucoes.sv
// Bench for busca_instrucoes: memory model, queue-level reference model
// compared every falling edge, plus directed literal expectations.
module tb_busca_instrucoes;

   logic clk;
   logic rst_n;
   busca_instrucoes_if bus ();

   busca_instrucoes dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [256];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(8'hA0 + i);
   end

   always @(negedge clk) bus.instruction_in <= mem[bus.address];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [7:0] ins;
      logic [7:0] pc;
   } ent_t;

   ent_t       mq [$];
   logic [7:0] m_pc;
   logic       m_primed;

   // Reference model: queue of fetched entries, expected byte taken from mem[pc].
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_pc     = 8'h00;
         m_primed = 1'b0;
      end else begin
         bit do_pop;
         bit do_cap;
         int sz;
         sz     = mq.size();
         do_pop = (sz > 0) && (bus.instr_ready === 1'b1);
         if (bus.desvio === 1'b1) begin
            mq.delete();
            m_pc = bus.desvio_alvo;
         end else begin
            do_cap = m_primed && (sz < 2 || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_cap) begin
               mq.push_back('{ins: mem[m_pc], pc: m_pc});
               m_pc = m_pc + 8'd1;
            end
         end
         m_primed = 1'b1;
      end
   end

   always @(negedge clk) begin
      logic       ev;
      logic [7:0] ei, ep;
      ev = (mq.size() != 0);
      ei = ev ? mq[0].ins : 8'h00;
      ep = ev ? mq[0].pc  : 8'h00;
      chk("model_address", bus.address, m_pc);
      chk("model_valid", {7'd0, bus.instr_valid}, {7'd0, ev});
      chk("model_instr", bus.instr, ei);
      chk("model_instr_pc", bus.instr_pc, ep);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic head(input string name, input logic [7:0] ei, input logic [7:0] ep);
      chk({name, "_valid"}, {7'd0, bus.instr_valid}, 8'd1);
      chk({name, "_instr"}, bus.instr, ei);
      chk({name, "_pc"}, bus.instr_pc, ep);
   endtask

   task automatic empty(input string name);
      chk({name, "_valid"}, {7'd0, bus.instr_valid}, 8'd0);
      chk({name, "_instr"}, bus.instr, 8'h00);
      chk({name, "_pc"}, bus.instr_pc, 8'h00);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.instr_ready = 1'b1;
      bus.desvio      = 1'b0;
      bus.desvio_alvo = 8'h00;
      step();
      chk("rst_address", bus.address, 8'h00);
      empty("rst");
      step();
      rst_n = 1'b1;

      // Reset release to stream
      step();
      empty("edge1");
      step();
      head("edge2", 8'hA0, 8'h00);
      chk("edge2_address", bus.address, 8'h01);
      step();
      head("edge3", 8'hA1, 8'h01);
      step();
      head("edge4", 8'hA2, 8'h02);

      // Backpressure for 5 cycles
      bus.instr_ready = 1'b0;
      repeat (5) step();
      head("bp_hold", 8'hA2, 8'h02);
      chk("bp_address", bus.address, 8'h04);
      bus.instr_ready = 1'b1;
      step();
      head("bp_rel1", 8'hA3, 8'h03);
      chk("bp_rel1_address", bus.address, 8'h05);
      step();
      head("full_pp", 8'hA4, 8'h04);
      chk("full_pp_address", bus.address, 8'h06);

      // Branch with 2 entries queued and ready high
      bus.desvio      = 1'b1;
      bus.desvio_alvo = 8'h40;
      step();
      bus.desvio = 1'b0;
      empty("br_bubble");
      chk("br_address", bus.address, 8'h40);
      step();
      head("br_t0", 8'hE0, 8'h40);
      step();
      head("br_t1", 8'hE1, 8'h41);

      // Consecutive redirects, last one wins, then wrap-around
      bus.desvio      = 1'b1;
      bus.desvio_alvo = 8'h10;
      step();
      bus.desvio_alvo = 8'hFE;
      step();
      bus.desvio = 1'b0;
      empty("br2_bubble");
      chk("br2_address", bus.address, 8'hFE);
      step();
      head("wrap_fe", 8'h9E, 8'hFE);
      step();
      head("wrap_ff", 8'h9F, 8'hFF);
      step();
      head("wrap_00", 8'hA0, 8'h00);
      step();
      head("wrap_01", 8'hA1, 8'h01);

      // Fill queue then asynchronous reset mid-cycle
      bus.instr_ready = 1'b0;
      step();
      step();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_address", bus.address, 8'h00);
      empty("async");
      bus.instr_ready = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      empty("rerst_edge1");
      step();
      head("rerst_edge2", 8'hA0, 8'h00);
      step();
      head("rerst_edge3", 8'hA1, 8'h01);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
